pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic, parametrised pipeline stage register: the successor to the hand-written per-stage latches.
//  Carries a packed payload of DATA_W bits between two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Uses a valid/ready handshake and a 2-entry skid buffer, so in_ready is registered (no comb ready chain).
//  Synchronous flush inserts a zeroed bubble (all control fields 0 => no RegWr/dWEN/halt).
// PARAMETERS
//  DATA_W   160   payload width in bits (packed stage struct)
//  CNT_W    32    width of performance counters (PIPE_PERF_EN only)
// PORTS
//  CLK         in   1        clock, rising edge
//  nRST        in   1        asynchronous, active-low reset
//  flush       in   1        synchronous flush: discard all held entries and the current input
//  in_valid    in   1        upstream payload valid
//  in_ready    out  1        stage can accept: in_valid & in_ready = transfer
//  in_data     in   DATA_W   upstream payload
//  out_valid   out  1        out_data holds a live entry
//  out_ready   in   1        downstream accepts: out_valid & out_ready = transfer
//  out_data    out  DATA_W   payload to downstream, driven from main register
//  stall_cnt   out  CNT_W    [PIPE_PERF_EN] cycles with out_valid & !out_ready
//  bubble_cnt  out  CNT_W    [PIPE_PERF_EN] cycles with !out_valid
//  flush_cnt   out  CNT_W    [PIPE_PERF_EN] cycles with flush=1
// BEHAVIOUR
//  Storage: main reg M (drives out_data), skid reg S. State pipe_state_t {EMPTY, BUSY, FULL}.
//  Reset (nRST=0, async): state=EMPTY, M=S='0, out_valid=0, out_data='0, counters=0.
//  Outputs: out_valid = (state!=EMPTY); in_ready = (state!=FULL) & !flush.
//  Latency: entry accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
//  Throughput 1 entry/cycle when out_ready held 1; order strictly FIFO; no duplication or drop.
//  Transitions (flush=0; in = in_valid&in_ready, out = out_valid&out_ready):
//   EMPTY: in -> M<=in_data, BUSY; else stay.
//   BUSY : in&out -> M<=in_data, BUSY; in&!out -> S<=in_data, FULL; !in&out -> EMPTY; else stay.
//   FULL : out -> M<=S, BUSY (in impossible, in_ready=0); else stay, M/S held.
//  Flush=1 (any state): next state EMPTY, M<='0, S<='0; input not transferred (in_ready=0);
//   the downstream transfer of the current out_data still counts if out_ready=1.
//  While stalled (out_valid & !out_ready) out_data and out_valid are held stable.
//  Freed registers keep stale data except on flush/reset; consumers qualify with out_valid.
//  Reset mid-transfer: all entries lost, state EMPTY immediately (async).
// CONFIGURATION
//  `PIPE_PERF_EN defined: stall_cnt/bubble_cnt/flush_cnt ports present; each increments by 1 on
//   its condition per cycle, saturates at 2**CNT_W-1, clears only on reset. Counts during flush too.
//  `PIPE_PERF_EN undefined: counter ports and logic absent; CNT_W unused; behaviour otherwise identical.
// STRUCTURE
//  cpu_types_pkg gains: typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;
//   and the packed per-stage payload structs (id_ex_t etc.) whose $bits set DATA_W at instantiation.
//  Single sub-module pipe_perf_cnt (saturating counter, width CNT_W), instantiated 3x
//   under `PIPE_PERF_EN; everything else flat in this module.
// TESTING (DATA_W=32 unless noted)
//  1 Reset: nRST=0 with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, in_ready=1; after
//    release, counters=0.
//  2 Stream: out_ready=1, push 1..8 on consecutive cycles -> out_data=1..8 on the 8 following cycles,
//    in_ready never 0.
//  3 Backpressure: push A,B with out_ready=0 -> FULL, in_ready=0, out_data=A held; out_ready=1 ->
//    A then B, in_ready=1 after A leaves.
//  4 Flush in FULL with in_valid=1, C presented -> next cycle out_valid=0, out_data=0; C not accepted;
//    later D emerges cleanly.
//  5 Simultaneous in&out in BUSY over 100 random cycles (random in_valid/out_ready) -> scoreboard:
//    output sequence equals accepted input sequence.
//  6 PIPE_PERF_EN, CNT_W=4: hold out_valid & !out_ready 20 cycles -> stall_cnt=15 (saturated);
//    3 flush cycles -> flush_cnt=3.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: shared state encoding and default widths for the skid-buffered pipeline stage.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;

    localparam int DATA_W_DEF = 160;
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready handshake bundle between two pipeline stages, plus synchronous flush.
interface pipe_stage_skid_if
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_stage_skid_perf_cnt.sv
// pipe_perf_cnt: saturating event counter, cleared only by asynchronous reset.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a 2-entry skid buffer and registered in_ready.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef PIPE_PERF_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    pipe_stage_skid_if.slave s
`ifdef PIPE_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] bubble_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_t       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_in;
    logic              w_out;

    assign s.out_valid = (r_state != EMPTY);
    assign s.in_ready  = (r_state != FULL) && !s.flush;
    assign s.out_data  = r_main;
    assign w_in        = s.in_valid && s.in_ready;
    assign w_out       = s.out_valid && s.out_ready;

    // Flush overrides every transition and zeroes both entries to form a clean bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (s.flush) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_in) begin
                    r_main  <= s.in_data;
                    r_state <= BUSY;
                end
                BUSY: if (w_in && w_out) begin
                    r_main <= s.in_data;
                end else if (w_in) begin
                    r_skid  <= s.in_data;
                    r_state <= FULL;
                end else if (w_out) begin
                    r_state <= EMPTY;
                end
                FULL: if (w_out) begin
                    r_main  <= r_skid;
                    r_state <= BUSY;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    pipe_perf_cnt #(.W(CNT_W)) u_stall (
        .CLK(CLK), .nRST(nRST), .i_inc(s.out_valid && !s.out_ready), .o_cnt(stall_cnt)
    );
    pipe_perf_cnt #(.W(CNT_W)) u_bubble (
        .CLK(CLK), .nRST(nRST), .i_inc(!s.out_valid), .o_cnt(bubble_cnt)
    );
    pipe_perf_cnt #(.W(CNT_W)) u_flush (
        .CLK(CLK), .nRST(nRST), .i_inc(s.flush), .o_cnt(flush_cnt)
    );
`endif

endmodule
